// File: rtl/irq_service_unit_if.sv
// Bundle of the interrupt-controller / CPU handshake signals seen by the
// interrupt service unit. The slave modport is the unit's view; the master
// modport is the view of whatever drives the controller status and CPU pins.
interface irq_service_unit_if #(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = 2
) ();

  logic [NUM_IRQ-1:0] pending_i;
  logic [NUM_IRQ-1:0] mask_i;
  logic               cpu_ack_i;
  logic               cpu_eoi_i;
  logic               cpu_irq_o;
  logic [VEC_W-1:0]   vector_o;
  logic               vector_valid_o;
  logic [NUM_IRQ-1:0] clear_o;
  logic               busy_o;
  logic               timeout_o;

  modport slave (
    input  pending_i,
    input  mask_i,
    input  cpu_ack_i,
    input  cpu_eoi_i,
    output cpu_irq_o,
    output vector_o,
    output vector_valid_o,
    output clear_o,
    output busy_o,
    output timeout_o
  );

  modport master (
    output pending_i,
    output mask_i,
    output cpu_ack_i,
    output cpu_eoi_i,
    input  cpu_irq_o,
    input  vector_o,
    input  vector_valid_o,
    input  clear_o,
    input  busy_o,
    input  timeout_o
  );

endinterface

// File: rtl/irq_service_unit.sv
// CPU-side interrupt responder. Masks the controller's pending vector, picks
// the lowest-numbered eligible source, raises a request to the CPU, and on
// acknowledge returns a one-cycle clear pulse for the serviced source. The
// request is abandoned (with a timeout pulse) if the CPU never acknowledges.
// Every output comes straight from a flop.
module irq_service_unit #(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             pclk_i,
  input  logic             rst_i,
  irq_service_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Lowest set index wins: bit 0 has the highest priority.
  function automatic logic [VEC_W-1:0] lowest_index(input logic [NUM_IRQ-1:0] bits);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = VEC_W'(i);
      end
    end
    return idx;
  endfunction

  // One-hot decode of a source index into a clear vector.
  function automatic logic [NUM_IRQ-1:0] one_hot(input logic [VEC_W-1:0] idx);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (VEC_W'(i) == idx) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [VEC_W-1:0]   vec_r, vec_s;
  logic               irq_r, irq_s;
  logic               valid_r, valid_s;
  logic [NUM_IRQ-1:0] clear_r, clear_s;
  logic               busy_r, busy_s;
  logic               timeout_r, timeout_s;
  logic [NUM_IRQ-1:0] eligible_s;

  assign eligible_s = bus.pending_i & bus.mask_i;

  // State, counter, latched winner and all output flops.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      vec_r     <= '0;
      irq_r     <= 1'b0;
      valid_r   <= 1'b0;
      clear_r   <= '0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      vec_r     <= vec_s;
      irq_r     <= irq_s;
      valid_r   <= valid_s;
      clear_r   <= clear_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state and next-output decode; outputs are computed for the state
  // being entered so they appear registered one cycle after the decision.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    vec_s     = vec_r;
    irq_s     = 1'b0;
    valid_s   = 1'b0;
    clear_s   = '0;
    timeout_s = 1'b0;
    busy_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          vec_s   = lowest_index(eligible_s);
          cnt_s   = '0;
          irq_s   = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end

      REQ: begin
        // Winner is frozen here; an ack on the final allowed cycle beats
        // the timeout.
        if (bus.cpu_ack_i) begin
          valid_s = 1'b1;
          clear_s = one_hot(vec_r);
          state_s = SERVICE;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          irq_s   = 1'b1;
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = REQ;
        end
      end

      SERVICE: begin
        if (bus.cpu_eoi_i) begin
          state_s = DONE;
        end else begin
          valid_s = 1'b1;
          state_s = SERVICE;
        end
      end

      DONE: begin
        // Gap cycle so the controller's cleared bit is seen before the
        // next arbitration.
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  assign bus.cpu_irq_o      = irq_r;
  assign bus.vector_o       = vec_r;
  assign bus.vector_valid_o = valid_r;
  assign bus.clear_o        = clear_r;
  assign bus.busy_o         = busy_r;
  assign bus.timeout_o      = timeout_r;

endmodule
